// File: rtl/utm_core.sv
// rtl/utm_core.sv - 4-state 2-symbol busy beaver transition engine
// Optional macro UTM_UNDEF_HALT_EN: undefined table entries halt instead of write-back/move-right.
module utm_core (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic [2:0] encoded_state_in,
  input  logic [2:0] sym_in,
  input  logic       sym_in_valid,
  output logic [2:0] new_sym,
  output logic       direction,
  output logic [2:0] encoded_next_state
);

  localparam logic [2:0] ST_A    = 3'd0;
  localparam logic [2:0] ST_B    = 3'd1;
  localparam logic [2:0] ST_C    = 3'd2;
  localparam logic [2:0] ST_D    = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd7;

  logic [2:0] state;
  logic [2:0] lookup_state;
  logic [2:0] lut_sym;
  logic       lut_dir;
  logic [2:0] lut_next;
  logic       halted;

  assign lookup_state = mode ? state : encoded_state_in;
  assign halted       = mode && (state == ST_HALT);

  always_comb begin
    lut_sym  = sym_in;
`ifdef UTM_UNDEF_HALT_EN
    lut_dir  = 1'b0;
    lut_next = ST_HALT;
`else
    lut_dir  = 1'b1;
    lut_next = lookup_state;
`endif
    if (lookup_state == ST_HALT) begin
      lut_sym  = sym_in;
      lut_dir  = 1'b0;
      lut_next = ST_HALT;
    end else if (sym_in[2:1] == 2'b00) begin
      // Defined region: states A..D with symbol 0 or 1
      case ({lookup_state, sym_in[0]})
        {ST_A, 1'b0}: begin lut_sym = 3'd1; lut_dir = 1'b1; lut_next = ST_B;    end
        {ST_A, 1'b1}: begin lut_sym = 3'd1; lut_dir = 1'b0; lut_next = ST_B;    end
        {ST_B, 1'b0}: begin lut_sym = 3'd1; lut_dir = 1'b0; lut_next = ST_A;    end
        {ST_B, 1'b1}: begin lut_sym = 3'd0; lut_dir = 1'b0; lut_next = ST_C;    end
        {ST_C, 1'b0}: begin lut_sym = 3'd1; lut_dir = 1'b1; lut_next = ST_HALT; end
        {ST_C, 1'b1}: begin lut_sym = 3'd1; lut_dir = 1'b0; lut_next = ST_D;    end
        {ST_D, 1'b0}: begin lut_sym = 3'd1; lut_dir = 1'b1; lut_next = ST_D;    end
        {ST_D, 1'b1}: begin lut_sym = 3'd0; lut_dir = 1'b1; lut_next = ST_A;    end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= ST_A;
      new_sym            <= 3'd0;
      direction          <= 1'b0;
      encoded_next_state <= 3'd0;
    end else if (sym_in_valid && !halted) begin
      new_sym            <= lut_sym;
      direction          <= lut_dir;
      encoded_next_state <= lut_next;
      if (mode)
        state <= lut_next;
    end
  end

endmodule

// File: tb/tb_utm_core.sv
// tb/tb_utm_core.sv - directed and randomized self-checking bench for utm_core
module tb_utm_core;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b1;
  logic [2:0] encoded_state_in = 3'd0;
  logic [2:0] sym_in = 3'd0;
  logic       sym_in_valid = 1'b0;
  logic [2:0] new_sym;
  logic       direction;
  logic [2:0] encoded_next_state;

  int n_checks = 0;
  int n_fail = 0;

  // Busy beaver table indexed by state*2+symbol
  int wr_tab[8]  = '{1, 1, 1, 0, 1, 1, 1, 0};
  int dir_tab[8] = '{1, 0, 0, 0, 1, 0, 1, 1};
  int nxt_tab[8] = '{1, 1, 0, 2, 7, 3, 3, 0};

  utm_core dut (
    .clock(clock), .reset(reset), .mode(mode),
    .encoded_state_in(encoded_state_in), .sym_in(sym_in), .sym_in_valid(sym_in_valid),
    .new_sym(new_sym), .direction(direction), .encoded_next_state(encoded_next_state)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] ref_step(int st, int sym);
    if (st == 7) return {sym[2:0], 1'b0, 3'd7};
    if (st > 3 || sym > 1) begin
`ifdef UTM_UNDEF_HALT_EN
      return {sym[2:0], 1'b0, 3'd7};
`else
      return {sym[2:0], 1'b1, st[2:0]};
`endif
    end
    return {wr_tab[st*2+sym][2:0], dir_tab[st*2+sym][0], nxt_tab[st*2+sym][2:0]};
  endfunction

  function automatic logic [6:0] outs();
    return {new_sym, direction, encoded_next_state};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic [2:0] esi, input logic [2:0] s);
    mode = m; encoded_state_in = esi; sym_in = s; sym_in_valid = 1'b1;
    @(posedge clock); #1;
    sym_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  int tape[512];
  int head;
  int steps;
  int ones;
  int mstate;
  logic [6:0] exp_out;
  logic [6:0] r;

  initial begin
    #1;
    do_reset();
    repeat (2) @(posedge clock);
    #1 check("reset_state", outs(), 7'h00);

    step(1'b1, 3'd0, 3'd0);
    check("first_step_A0", outs(), {3'd1, 1'b1, 3'd1});

    reset = 1'b0; sym_in_valid = 1'b1; sym_in = 3'd1;
    repeat (2) @(posedge clock);
    #1 check("reset_over_valid", outs(), 7'h00);
    sym_in_valid = 1'b0; reset = 1'b1;
    step(1'b1, 3'd0, 3'd1);
    check("after_release_A1", outs(), {3'd1, 1'b0, 3'd1});

    do_reset();
    step(1'b0, 3'd2, 3'd0);
    check("ext_C0", outs(), {3'd1, 1'b1, 3'd7});
    step(1'b1, 3'd0, 3'd0);
    check("int_untouched", outs(), {3'd1, 1'b1, 3'd1});

    step(1'b0, 3'd5, 3'd3);
`ifdef UTM_UNDEF_HALT_EN
    check("undef_entry", outs(), {3'd3, 1'b0, 3'd7});
`else
    check("undef_entry", outs(), {3'd3, 1'b1, 3'd5});
`endif
    step(1'b0, 3'd7, 3'd1);
    check("ext_halt", outs(), {3'd1, 1'b0, 3'd7});

    // Walk A -> B -> C -> D, then back-to-back pulses
    do_reset();
    step(1'b1, 3'd0, 3'd1);
    step(1'b1, 3'd0, 3'd1);
    step(1'b1, 3'd0, 3'd1);
    check("reach_D", outs(), {3'd1, 1'b0, 3'd3});
    mode = 1'b1; sym_in = 3'd1; sym_in_valid = 1'b1;
    @(posedge clock); #1;
    check("b2b_first_D1", outs(), {3'd0, 1'b1, 3'd0});
    sym_in = 3'd0;
    @(posedge clock); #1;
    sym_in_valid = 1'b0;
    check("b2b_second_A0", outs(), {3'd1, 1'b1, 3'd1});
    repeat (3) @(posedge clock);
    #1 check("idle_hold", outs(), {3'd1, 1'b1, 3'd1});

    // Full busy beaver run on a blank tape
    do_reset();
    foreach (tape[i]) tape[i] = 0;
    head = 256; steps = 0; mstate = 0;
    while (mstate != 7 && steps < 200) begin
      exp_out = ref_step(mstate, tape[head]);
      step(1'b1, 3'd0, tape[head][2:0]);
      steps++;
      check($sformatf("bb_step%0d", steps), outs(), exp_out);
      mstate = int'(exp_out[2:0]);
      tape[head] = int'(new_sym);
      head = direction ? head + 1 : head - 1;
      if (head < 0 || head > 511) begin
        check("tape_bounds", 7'(head), 7'd0);
        steps = 200;
      end
    end
    ones = 0;
    foreach (tape[i]) if (tape[i] == 1) ones++;
    check("bb_steps", 7'(steps), 7'd107);
    check("bb_ones", 7'(ones), 7'd13);
    check("bb_halt_state", 7'(encoded_next_state), 7'd7);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd0, 3'($urandom_range(0, 1)));
      check("halt_hold", outs(), {3'd1, 1'b1, 3'd7});
    end

    // Randomized steps against the reference model
    do_reset();
    mstate = 0; exp_out = 7'h00;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      mode = 1'($urandom_range(0, 1));
      encoded_state_in = 3'($urandom_range(0, 7));
      sym_in = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      sym_in_valid = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 29) != 0);
      if (!reset) begin
        mstate = 0; exp_out = 7'h00;
      end else if (sym_in_valid && !(mode && mstate == 7)) begin
        r = ref_step(mode ? mstate : int'(encoded_state_in), int'(sym_in));
        exp_out = r;
        if (mode) mstate = int'(r[2:0]);
      end
      @(posedge clock); #1;
      check($sformatf("rand%0d", k), outs(), exp_out);
    end
    sym_in_valid = 1'b0; reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
